// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard scan-code controller:
// FSM state encoding and the default prefix byte values.
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POP     = 2'd2,
      ST_SETTLE  = 2'd3
   } kbd_state_e;

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

endpackage

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code decoder sitting beside the keyboard receiver FIFO.
// Pulls one byte per four-cycle transaction, tracks E0/F0 prefixes and
// reports the currently held key, make/break strobes and a make counter.
module kbd_scan_ctrl #(
   parameter int unsigned COUNT_W  = 8,
   parameter logic [7:0]  BRK_CODE = kbd_pkg::BRK_CODE,
   parameter logic [7:0]  EXT_CODE = kbd_pkg::EXT_CODE
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               ready,
   input  logic [7:0]         data,
   input  logic               overflow,
   output logic               nextdata_n,
   output logic [7:0]         key_code,
   output logic               key_valid,
   output logic               key_ext,
   output logic [COUNT_W-1:0] key_count,
   output logic               make_pulse,
   output logic               break_pulse,
   output logic               ovf_seen
);
   import kbd_pkg::*;

   kbd_state_e         state_q, state_d;
   logic [7:0]         byte_q, byte_d;
   logic [7:0]         key_code_q, key_code_d;
   logic               key_valid_q, key_valid_d;
   logic               key_ext_q, key_ext_d;
   logic [COUNT_W-1:0] key_count_q, key_count_d;
   logic               make_q, make_d;
   logic               break_q, break_d;
   logic               ovf_q, ovf_d;
   logic               brk_pend_q, brk_pend_d;
   logic               ext_pend_q, ext_pend_d;
   logic               same_key;

   // The held key matches the registered byte including its extended flag.
   assign same_key = key_valid_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

   // Next-state, byte capture and scan-code decode; decode only fires in POP.
   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      key_ext_d   = key_ext_q;
      key_count_d = key_count_q;
      make_d      = 1'b0;
      break_d     = 1'b0;
      ovf_d       = ovf_q | overflow;
      brk_pend_d  = brk_pend_q;
      ext_pend_d  = ext_pend_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ready) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            byte_d  = data;
            state_d = ST_POP;
         end
         ST_POP: begin
            state_d = ST_SETTLE;
            if (byte_q == EXT_CODE) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == BRK_CODE) begin
               brk_pend_d = 1'b1;
            end else if (brk_pend_q) begin
               if (same_key) begin
                  key_valid_d = 1'b0;
                  key_ext_d   = 1'b0;
                  break_d     = 1'b1;
               end
               brk_pend_d = 1'b0;
               ext_pend_d = 1'b0;
            end else if (same_key) begin
               // Typematic repeat of the held key: swallow it silently.
               ext_pend_d = 1'b0;
            end else begin
               key_code_d  = byte_q;
               key_ext_d   = ext_pend_q;
               key_valid_d = 1'b1;
               key_count_d = key_count_q + COUNT_W'(1);
               make_d      = 1'b1;
               ext_pend_d  = 1'b0;
            end
         end
         // SETTLE ignores ready so the receiver read pointer can advance.
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and decode registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         byte_q      <= 8'h00;
         key_code_q  <= 8'h00;
         key_valid_q <= 1'b0;
         key_ext_q   <= 1'b0;
         key_count_q <= '0;
         make_q      <= 1'b0;
         break_q     <= 1'b0;
         ovf_q       <= 1'b0;
         brk_pend_q  <= 1'b0;
         ext_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_q      <= byte_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_ext_q   <= key_ext_d;
         key_count_q <= key_count_d;
         make_q      <= make_d;
         break_q     <= break_d;
         ovf_q       <= ovf_d;
         brk_pend_q  <= brk_pend_d;
         ext_pend_q  <= ext_pend_d;
      end
   end

   assign nextdata_n  = (state_q != ST_POP);
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_ext     = key_ext_q;
   assign key_count   = key_count_q;
   assign make_pulse  = make_q;
   assign break_pulse = break_q;
   assign ovf_seen    = ovf_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with a reference decode model and a
// scoreboard of expected strobes per consumed byte.
module tb_kbd_scan_ctrl;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] data = 8'h00;
   logic       overflow = 1'b0;
   logic       nextdata_n;
   logic [7:0] key_code;
   logic       key_valid;
   logic       key_ext;
   logic [7:0] key_count;
   logic       make_pulse;
   logic       break_pulse;
   logic       ovf_seen;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [7:0] m_code = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_kext = 1'b0;
   logic [7:0] m_count = 8'h00;
   logic       m_brk = 1'b0;
   logic       m_extp = 1'b0;
   int         m_makes = 0;
   int         m_breaks = 0;
   int         bytes_sent = 0;
   int         sb_q[$];

   // Observed event counters
   int pop_cnt = 0;
   int make_cnt = 0;
   int brk_cnt = 0;
   int both_cnt = 0;

   kbd_scan_ctrl #(.COUNT_W(8), .BRK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
      .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
      .nextdata_n(nextdata_n), .key_code(key_code), .key_valid(key_valid),
      .key_ext(key_ext), .key_count(key_count), .make_pulse(make_pulse),
      .break_pulse(break_pulse), .ovf_seen(ovf_seen)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (clrn === 1'b1) begin
         if (nextdata_n === 1'b0) pop_cnt++;
         if (make_pulse === 1'b1) make_cnt++;
         if (break_pulse === 1'b1) brk_cnt++;
         if (make_pulse === 1'b1 && break_pulse === 1'b1) both_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_code = 8'h00; m_valid = 1'b0; m_kext = 1'b0; m_count = 8'h00;
      m_brk = 1'b0; m_extp = 1'b0;
      sb_q.delete();
   endtask

   // kind: 0 = no strobe, 1 = make, 2 = break
   task automatic model_byte(input logic [7:0] b, output int kind);
      logic match;
      kind = 0;
      match = m_valid && (b == m_code) && (m_extp == m_kext);
      if (b == 8'hE0) m_extp = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) begin
         if (match) begin
            m_valid = 1'b0; m_kext = 1'b0; kind = 2; m_breaks++;
         end
         m_brk = 1'b0; m_extp = 1'b0;
      end else if (match) begin
         m_extp = 1'b0;
      end else begin
         m_code = b; m_kext = m_extp; m_valid = 1'b1;
         m_count = m_count + 8'd1; m_makes++; kind = 1; m_extp = 1'b0;
      end
   endtask

   task automatic check_key(input string tag);
      check({tag, "_code"},  key_code, m_code);
      check({tag, "_valid"}, key_valid, m_valid);
      check({tag, "_ext"},   key_ext, m_kext);
      check({tag, "_count"}, key_count, m_count);
   endtask

   // Present one byte at the FIFO head, wait for its pop, then compare strobes.
   task automatic send_byte(input logic [7:0] b, input bit full_check);
      int kind;
      int n;
      model_byte(b, kind);
      sb_q.push_back(kind);
      bytes_sent++;
      ready = 1'b1;
      data  = b;
      n = 0;
      @(negedge clk);
      while (nextdata_n !== 1'b0 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (nextdata_n !== 1'b0) check("pop_timeout", {31'd0, nextdata_n}, 32'd0);
      ready = 1'b0;
      @(negedge clk);
      kind = sb_q.pop_front();
      if (full_check) begin
         check("make_pulse",  make_pulse,  (kind == 1));
         check("break_pulse", break_pulse, (kind == 2));
         check("nextdata_settle", nextdata_n, 1'b1);
         check_key("key");
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_nextdata_n"}, nextdata_n, 1'b1);
      check({tag, "_code"},  key_code, 8'h00);
      check({tag, "_valid"}, key_valid, 1'b0);
      check({tag, "_ext"},   key_ext, 1'b0);
      check({tag, "_count"}, key_count, 8'h00);
      check({tag, "_make"},  make_pulse, 1'b0);
      check({tag, "_break"}, break_pulse, 1'b0);
      check({tag, "_ovf"},   ovf_seen, 1'b0);
   endtask

   initial begin
      int pops0;
      logic [7:0] alt;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      clrn = 1'b1;
      @(negedge clk);
      check("idle_nextdata_n", nextdata_n, 1'b1);

      // Single make
      pops0 = pop_cnt;
      send_byte(8'h1C, 1'b1);
      check("single_pops", pop_cnt - pops0, 1);

      // Make then release of the same key
      pops0 = pop_cnt;
      send_byte(8'hF0, 1'b1);
      send_byte(8'h1C, 1'b1);
      check("release_pops", pop_cnt - pops0, 2);

      // Typematic repeats then release
      send_byte(8'h1B, 1'b1);
      send_byte(8'h1B, 1'b1);
      send_byte(8'h1B, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h1B, 1'b1);

      // Extended key: a plain release must not break it, extended release does
      send_byte(8'hE0, 1'b1);
      send_byte(8'h75, 1'b1);
      check("ext_held", key_ext, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h75, 1'b1);
      send_byte(8'hE0, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h75, 1'b1);
      check("ext_released", key_valid, 1'b0);

      // Release of a key that is not held: no strobe
      send_byte(8'hF0, 1'b1);
      send_byte(8'h22, 1'b1);

      // Overflow flag is sticky and does not disturb decoding
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      @(negedge clk);
      check("ovf_set", ovf_seen, 1'b1);

      // Counter wrap: 2^8+1 alternating makes from a cleared counter
      clrn = 1'b0;
      model_reset();
      #1;
      check_reset_values("wrap_rst");
      @(negedge clk);
      clrn = 1'b1;
      alt = 8'h1C;
      for (int i = 0; i < 257; i++) begin
         send_byte(alt, (i < 3) || (i > 253));
         alt = (alt == 8'h1C) ? 8'h1B : 8'h1C;
      end
      check("wrap_count", key_count, 8'd1);
      check("ovf_before_rst", ovf_seen, 1'b0);
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      send_byte(8'h2A, 1'b1);
      check("ovf_sticky", ovf_seen, 1'b1);

      // Reset with a pending break prefix
      send_byte(8'hF0, 1'b1);
      @(negedge clk);
      clrn = 1'b0;
      model_reset();
      #1;
      check_reset_values("mid_rst");
      @(negedge clk);
      clrn = 1'b1;
      send_byte(8'h1C, 1'b1);
      check("post_rst_count", key_count, 8'd1);

      repeat (4) @(negedge clk);
      check("total_pops", pop_cnt, bytes_sent);
      check("total_makes", make_cnt, m_makes);
      check("total_breaks", brk_cnt, m_breaks);
      check("pulse_overlap", both_cnt, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kbd_scan_ctrl.md
KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 Parameter COUNT_W, default 8: width of key press counter.
REQ-002 Parameter BRK_CODE, default 8'hF0: break prefix byte.
REQ-003 Parameter EXT_CODE, default 8'hE0: extended prefix byte.
REQ-004 clk  input  1: single system clock; all state updates on rising edge.
REQ-005 clrn  input  1: reset, asynchronous, active-low.
REQ-006 ready  input  1: receiver FIFO non-empty.
REQ-007 data  input  8: receiver FIFO head byte, valid while ready=1.
REQ-008 overflow  input  1: receiver FIFO overflow flag.
REQ-009 nextdata_n  output  1: active-low pop strobe to receiver.
REQ-010 key_code  output  8: scan code of key currently held.
REQ-011 key_valid  output  1: a key is currently held.
REQ-012 key_ext  output  1: held key was E0-prefixed.
REQ-013 key_count  output  COUNT_W: number of distinct make events.
REQ-014 make_pulse  output  1: one-cycle strobe on new key press.
REQ-015 break_pulse  output  1: one-cycle strobe on key release.
REQ-016 ovf_seen  output  1: sticky record of receiver overflow.

Function
REQ-017 FSM states: IDLE, CAPTURE, POP, SETTLE; IDLE->CAPTURE when ready=1; CAPTURE->POP unconditionally; POP->SETTLE; SETTLE->IDLE.
REQ-018 CAPTURE registers data into an internal byte register; decode acts on the registered byte in POP.
REQ-019 nextdata_n SHALL be 0 for exactly the one cycle in POP and 1 in every other state; one pop per consumed byte.
REQ-020 SETTLE SHALL ignore ready so the receiver read pointer updates before the next sample; throughput max one byte per 4 cycles.
REQ-021 Byte == EXT_CODE: set ext_pending; no output change.
REQ-022 Byte == BRK_CODE: set brk_pending; no output change.
REQ-023 Other byte with brk_pending=1: if key_valid=1 and byte==key_code and ext_pending==key_ext, clear key_valid and key_ext and pulse break_pulse; otherwise no key change and no pulse; clear brk_pending and ext_pending in both cases.
REQ-024 Other byte with brk_pending=0 and key_valid=1 and byte==key_code and ext_pending==key_ext: typematic repeat; no pulse, no count change; clear ext_pending.
REQ-025 Other byte with brk_pending=0, any other case: key_code<=byte, key_ext<=ext_pending, key_valid<=1, key_count increments, make_pulse=1; clear ext_pending.
REQ-026 key_count wraps from 2^COUNT_W-1 to 0 without saturation.
REQ-027 make_pulse and break_pulse SHALL assert in the cycle after POP, for one cycle, and never simultaneously.
REQ-028 ovf_seen SHALL set on any cycle with overflow=1 and clear only on reset; overflow does not alter FSM operation.
REQ-029 A BRK_CODE received while brk_pending=1 keeps brk_pending=1 (duplicate prefix tolerated).

Reset
REQ-030 clrn=0 SHALL immediately force state IDLE, nextdata_n=1, key_code=8'h00, key_valid=0, key_ext=0, key_count=0, make_pulse=0, break_pulse=0, ovf_seen=0, brk_pending=0, ext_pending=0.
REQ-031 Reset mid-sequence (e.g. after F0 before code) SHALL discard pending prefixes; the first post-reset byte is decoded as a fresh byte.
REQ-032 After deassertion, first FIFO sample occurs no earlier than the first rising edge with clrn=1.

Structure
REQ-033 Shared package kbd_pkg holds FSM state encoding (2-bit enum) and constants BRK_CODE=8'hF0, EXT_CODE=8'hE0.
REQ-034 Single module, no sub-modules; decode logic inline; instantiated beside ps2_keyboard with ready/data/overflow/nextdata_n wired directly.

Verification
REQ-035 Receiver sends 1C -> one 0-pulse on nextdata_n, make_pulse once, key_code=1C, key_valid=1, key_count=1.
REQ-036 Sequence 1C,F0,1C -> make then break_pulse; key_valid=0, key_count=1, exactly three nextdata_n pulses.
REQ-037 Sequence 1B,1B,1B,F0,1B -> one make_pulse, one break_pulse, key_count=1, key_valid=0 at end.
REQ-038 Sequence E0,75,E0,F0,75 -> key_code=75 with key_ext=1 after make; break_pulse and key_ext=0 at end; 75,F0-then-E0-less release of 75 does not break an extended key.
REQ-039 2^COUNT_W+1 distinct alternating makes (1C,1B,...) -> key_count wraps to 1; overflow=1 for one cycle -> ovf_seen=1 until clrn=0.
REQ-040 Assert clrn=0 after F0 received, release, send 1C -> treated as make: make_pulse=1, key_count=1.
